fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per character.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range is 2 or more.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning that 1 inserts an even-parity bit after the data bits.
REQ-004 SHALL have port clk, input, width 1, meaning the clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, width 1, meaning reset; synchronous, active-high.
REQ-006 SHALL have port enable, input, width 1, meaning new frames may start.
REQ-007 SHALL have port fifo_empty, input, width 1, meaning the upstream sync FIFO's empty flag.
REQ-008 SHALL have port fifo_data, input, width DATA_WIDTH, meaning the upstream FIFO's registered read data, valid the cycle after a pop.
REQ-009 SHALL have port fifo_rd, output, width 1, meaning the registered pop strobe to the upstream FIFO.
REQ-010 SHALL have port tx, output, width 1, meaning the registered serial line, idle high.
REQ-011 SHALL have port busy, output, width 1, meaning high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
REQ-013 SHALL move IDLE->FETCH when enable=1 and fifo_empty=0; otherwise it stays in IDLE.
REQ-014 SHALL drive fifo_rd=1 in FETCH only, for exactly one cycle per character; FETCH->WAIT is unconditional.
REQ-015 SHALL load fifo_data into the shift register at the end of WAIT, then go WAIT->START.
REQ-016 SHALL drive tx=0 in START, then tx=data bits LSB first in DATA, then tx=parity in PARITY, then tx=1 in STOP; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 SHALL count DATA_WIDTH bits in DATA, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-018 SHALL compute the parity bit as the XOR of the loaded character, so the total count of ones is even.
REQ-019 SHALL hold tx=1 in IDLE, FETCH and WAIT.
REQ-020 SHALL, at the last STOP cycle, go to FETCH if enable=1 and fifo_empty=0, else to IDLE; back-to-back frames are thus separated by exactly 2 extra idle-high cycles.
REQ-021 SHALL produce tx falling 3 cycles after the cycle in which IDLE sees enable=1 and fifo_empty=0 (fifo_rd at +1, capture at +2, START at +3).
REQ-022 SHALL sample enable only at frame-start decisions; deasserting enable mid-frame lets the current frame complete.
REQ-023 SHALL ignore fifo_empty and fifo_data outside the decision and capture points, and never assert fifo_rd while fifo_empty=1 was sampled at the decision.
REQ-024 SHALL use a baud counter of width clog2(CLKS_PER_BIT) that wraps to 0 at CLKS_PER_BIT-1; the bit counter resets on entry to DATA.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, tx=1, fifo_rd=0, busy=0, and all counters and the shift register to 0 on the next edge.
REQ-026 SHALL abort any frame on reset mid-operation; tx returns high on the next edge and the popped character is discarded, with no re-pop.
REQ-027 SHALL give rst priority over all other inputs.

Verification
REQ-028 SHALL cover: CLKS_PER_BIT=4, PARITY_EN=0, one entry 0xA5 -> single fifo_rd pulse; tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy high for 42 cycles.
REQ-029 SHALL cover: two entries 0x01 and 0x80 queued -> two fifo_rd pulses 42 cycles apart; exactly 2 high cycles between the first STOP and the second START.
REQ-030 SHALL cover: fifo_empty=0 with enable=0 for 50 cycles -> fifo_rd stays 0, tx stays 1, busy stays 0.
REQ-031 SHALL cover: PARITY_EN=1, character 0x07 -> parity bit 1 and frame length 11*CLKS_PER_BIT.
REQ-032 SHALL cover: rst pulsed during DATA bit 3 -> next cycle tx=1, busy=0, state IDLE; a following character transmits correctly.
REQ-033 SHALL cover: enable dropped during START -> the frame completes, and no further fifo_rd occurs while enable=0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls characters from an upstream synchronous FIFO.
// Frames are 8N1 by default, with an optional even-parity bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [CW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    rd_q, rd_d;
  logic                    baud_end;
  logic                    in_bit;
  logic                    start_ok;

  assign baud_end = (baud_q == BAUD_LAST);
  assign start_ok = enable && !fifo_empty;
  assign in_bit   = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = (!in_bit || baud_end) ? '0 : baud_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Read data is valid one cycle after the pop strobe.
        shift_d = fifo_data;
        par_d   = ^fifo_data;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        if (baud_end) state_d = start_ok ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rd_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = rd_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed by
// small FIFO models; tx traces are recorded and decoded against a scoreboard.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int NTR = 200;

  logic       clk;
  logic       rst;
  logic       mrst;
  logic       en0, en1;
  logic       fe0, fe1;
  logic [7:0] fd0, fd1;
  logic       rd0, rd1;
  logic       tx0, tx1;
  logic       busy0, busy1;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] wp0, wp1;
  logic [3:0] rp0, rp1;
  int         bad_pop;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  logic tx_tr   [NTR];
  logic busy_tr [NTR];
  logic rd_tr   [NTR];
  int   ntr;

  int n_chk;
  int n_pass;
  int n_fail;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .enable    (en0),
    .fifo_empty(fe0),
    .fifo_data (fd0),
    .fifo_rd   (rd0),
    .tx        (tx0),
    .busy      (busy0)
  );

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (en1),
    .fifo_empty(fe1),
    .fifo_data (fd1),
    .fifo_rd   (rd1),
    .tx        (tx1),
    .busy      (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fe0 = (wp0 == rp0);
  assign fe1 = (wp1 == rp1);

  // Upstream FIFO models: registered read data, one cycle after the pop.
  always @(posedge clk) begin
    if (mrst) begin
      rp0     <= '0;
      rp1     <= '0;
      bad_pop <= 0;
    end else begin
      if (rd0) begin
        fd0 <= mem0[rp0];
        rp0 <= rp0 + 4'd1;
      end
      if (rd1) begin
        fd1 <= mem1[rp1];
        rp1 <= rp1 + 4'd1;
      end
      if ((rd0 && fe0) || (rd1 && fe1)) bad_pop <= bad_pop + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] c);
    if (sel == 0) begin
      mem0[wp0] = c;
      wp0 = wp0 + 4'd1;
      exp0.push_back(c);
    end else begin
      mem1[wp1] = c;
      wp1 = wp1 + 4'd1;
      exp1.push_back(c);
    end
  endtask

  // kind 1: drop enable after sample ev; kind 2: pulse rst after sample ev.
  task automatic record(input int n, input int sel, input int ev,
                        input int kind);
    ntr = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_tr[i]   = (sel == 0) ? tx0 : tx1;
      busy_tr[i] = (sel == 0) ? busy0 : busy1;
      rd_tr[i]   = (sel == 0) ? rd0 : rd1;
      if (kind == 1 && i == ev) begin
        if (sel == 0) en0 = 1'b0;
        else en1 = 1'b0;
      end
      if (kind == 2 && i == ev) rst = 1'b1;
      if (kind == 2 && i == ev + 1) rst = 1'b0;
    end
  endtask

  function automatic logic trace(input int which, input int i);
    if (which == 0) return tx_tr[i];
    if (which == 1) return busy_tr[i];
    return rd_tr[i];
  endfunction

  function automatic int cnt(input int which, input int a, input int b,
                             input logic v);
    int n;
    n = 0;
    for (int i = a; i < b; i++) if (trace(which, i) === v) n++;
    return n;
  endfunction

  function automatic int find(input int which, input int from, input logic v);
    for (int i = from; i < ntr; i++) if (trace(which, i) === v) return i;
    return -1;
  endfunction

  function automatic int find_fall(input int from);
    for (int i = (from < 1 ? 1 : from); i < ntr; i++)
      if (tx_tr[i] === 1'b0 && tx_tr[i-1] === 1'b1) return i;
    return -1;
  endfunction

  task automatic check_frame(input string tag, input int sel, input int fall);
    int         par;
    int         errs;
    int         b;
    logic       e;
    logic [7:0] c;
    logic [7:0] d;
    par = sel;
    chk({tag, " sb"}, ((sel == 0) ? exp0.size() : exp1.size()) != 0, 1);
    if (fall < 0 || fall + (10 + par) * CPB > ntr) begin
      chk({tag, " bound"}, fall, 32'hffff_fffe);
      return;
    end
    if (sel == 0) c = (exp0.size() != 0) ? exp0.pop_front() : 8'h00;
    else c = (exp1.size() != 0) ? exp1.pop_front() : 8'h00;
    errs = 0;
    for (int k = 0; k < (10 + par) * CPB; k++) begin
      b = k / CPB;
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = c[b-1];
      else if (par != 0 && b == 9) e = ^c;
      else e = 1'b1;
      if (tx_tr[fall+k] !== e) errs++;
    end
    chk({tag, " wave"}, errs, 0);
    for (int j = 0; j < 8; j++) d[j] = tx_tr[fall + (j + 1) * CPB + CPB / 2];
    chk({tag, " char"}, d, c);
  endtask

  initial begin
    int f1;
    int f2;
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    ntr    = 0;
    wp0    = '0;
    wp1    = '0;
    rst    = 1'b1;
    mrst   = 1'b1;
    en0    = 1'b0;
    en1    = 1'b0;
    repeat (3) @(negedge clk);
    mrst = 1'b0;
    chk("rst tx0", tx0, 1);
    chk("rst busy0", busy0, 0);
    chk("rst rd0", rd0, 0);
    chk("rst tx1", tx1, 1);
    chk("rst busy1", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single character 0xA5.
    en0 = 1'b1;
    push(0, 8'hA5);
    record(60, 0, -1, 0);
    chk("T1 rd count", cnt(2, 0, 60, 1'b1), 1);
    chk("T1 rd index", find(2, 0, 1'b1), 0);
    chk("T1 busy len", cnt(1, 0, 60, 1'b1), 42);
    chk("T1 busy end", busy_tr[42], 0);
    f1 = find_fall(0);
    chk("T1 fall", f1, 2);
    check_frame("T1", 0, f1);

    // Back-to-back 0x01 then 0x80.
    push(0, 8'h01);
    push(0, 8'h80);
    record(100, 0, -1, 0);
    chk("T2 rd count", cnt(2, 0, 100, 1'b1), 2);
    chk("T2 rd2 index", find(2, 1, 1'b1), 42);
    chk("T2 busy len", cnt(1, 0, 100, 1'b1), 84);
    f1 = find_fall(0);
    f2 = find_fall(f1 + 10 * CPB);
    chk("T2 gap", f2 - (f1 + 10 * CPB), 2);
    check_frame("T2a", 0, f1);
    check_frame("T2b", 0, f2);

    // Data waiting while disabled.
    en0 = 1'b0;
    push(0, 8'h3C);
    record(50, 0, -1, 0);
    chk("T3 rd idle", cnt(2, 0, 50, 1'b1), 0);
    chk("T3 tx idle", cnt(0, 0, 50, 1'b1), 50);
    chk("T3 busy idle", cnt(1, 0, 50, 1'b1), 0);
    en0 = 1'b1;
    record(60, 0, -1, 0);
    f1 = find_fall(0);
    chk("T3 fall", f1, 2);
    check_frame("T3", 0, f1);

    // Even parity on 0x07.
    en1 = 1'b1;
    push(1, 8'h07);
    record(60, 1, -1, 0);
    f1 = find_fall(0);
    chk("T4 fall", f1, 2);
    chk("T4 busy len", cnt(1, 0, 60, 1'b1), 11 * CPB + 2);
    chk("T4 parity", tx_tr[2 + 9 * CPB + CPB / 2], 1);
    check_frame("T4", 1, f1);

    // Reset during data bit 3 of 0x33.
    push(0, 8'h33);
    record(30, 0, 19, 2);
    chk("T5 bit3", tx_tr[18], 0);
    chk("T5 tx after rst", tx_tr[20], 1);
    chk("T5 busy after rst", busy_tr[20], 0);
    chk("T5 no repop", cnt(2, 0, 30, 1'b1), 1);
    chk("T5 idle", cnt(1, 20, 30, 1'b1), 0);
    void'(exp0.pop_front());
    push(0, 8'hC3);
    record(60, 0, -1, 0);
    f1 = find_fall(0);
    chk("T5 fall", f1, 2);
    check_frame("T5", 0, f1);

    // Enable dropped during START with a second character queued.
    push(0, 8'h96);
    push(0, 8'h69);
    record(100, 0, 2, 1);
    chk("T6 start", tx_tr[2], 0);
    chk("T6 rd count", cnt(2, 0, 100, 1'b1), 1);
    chk("T6 busy len", cnt(1, 0, 100, 1'b1), 42);
    chk("T6 tx idle", cnt(0, 42, 100, 1'b1), 58);
    check_frame("T6a", 0, find_fall(0));
    en0 = 1'b1;
    record(60, 0, -1, 0);
    f1 = find_fall(0);
    chk("T6 fall", f1, 2);
    check_frame("T6b", 0, f1);

    chk("pop when empty", bad_pop, 0);
    chk("sb0 drained", exp0.size(), 0);
    chk("sb1 drained", exp1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
